// File: rtl/segre_mm_arbiter.sv
// Main-memory arbiter/sequencer. Serialises I$ refill reads, D$ refill reads
// and store write-through onto one memory port. Fixed priority
// store > D$ > I$, with an aging override so a waiting I$ refill cannot starve.

package segre_mm_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memop_data_type_e;
endpackage

module segre_mm_arbiter
    import segre_mm_pkg::*;
#(
    parameter int ADDR_SIZE   = 32,
    parameter int WORD_SIZE   = 32,
    parameter int LANE_SIZE   = 128,
    parameter int IC_MAX_WAIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ic_req_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_rdy_o,
    input  logic                 dc_req_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    output logic                 dc_rdy_o,
    input  logic                 st_req_i,
    input  logic [ADDR_SIZE-1:0] st_addr_i,
    input  logic [WORD_SIZE-1:0] st_data_i,
    input  memop_data_type_e     st_type_i,
    output logic                 st_ack_o,
    output logic [LANE_SIZE-1:0] rsp_data_o,
    output logic                 mm_rd_o,
    output logic [ADDR_SIZE-1:0] mm_addr_o,
    input  logic                 mm_data_rdy_i,
    input  logic [LANE_SIZE-1:0] mm_rd_data_i,
    output logic                 mm_wr_o,
    output logic [ADDR_SIZE-1:0] mm_wr_addr_o,
    output logic [WORD_SIZE-1:0] mm_wr_data_o,
    output memop_data_type_e     mm_wr_data_type_o
);
    localparam int OFFS = $clog2(LANE_SIZE / 8);
    localparam int WCW  = $clog2(IC_MAX_WAIT + 1);
    localparam logic [WCW-1:0] WMAX = WCW'(IC_MAX_WAIT);

    typedef enum logic [1:0] {IDLE, RD_IC, RD_DC, WR} state_e;

    state_e                 state_q, state_d;
    logic [WCW-1:0]         wait_q, wait_d;
    logic                   ic_rdy_d, dc_rdy_d, st_ack_d, mm_rd_d, mm_wr_d;
    logic [LANE_SIZE-1:0]   rsp_d;
    logic [ADDR_SIZE-1:0]   mm_addr_d, wr_addr_d;
    logic [WORD_SIZE-1:0]   wr_data_d;
    memop_data_type_e       wr_type_d;
    logic                   ic_req, dc_req, st_req;
    logic                   go_ic, go_dc, go_st;

    // A requester whose completion pulse is out this cycle may still hold req;
    // masking it here prevents a second issue of the same transaction.
    assign ic_req = ic_req_i & ~ic_rdy_o;
    assign dc_req = dc_req_i & ~dc_rdy_o;
    assign st_req = st_req_i & ~st_ack_o;

    // Next-state, wait counter and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ic_rdy_d  = 1'b0;
        dc_rdy_d  = 1'b0;
        st_ack_d  = 1'b0;
        mm_wr_d   = 1'b0;
        mm_rd_d   = mm_rd_o;
        mm_addr_d = mm_addr_o;
        rsp_d     = rsp_data_o;
        wr_addr_d = mm_wr_addr_o;
        wr_data_d = mm_wr_data_o;
        wr_type_d = mm_wr_data_type_o;
        go_ic     = ic_req && ((wait_q == WMAX) || (!st_req && !dc_req));
        go_st     = !go_ic && st_req;
        go_dc     = !go_ic && !st_req && dc_req;
        case (state_q)
            IDLE: begin
                if (go_ic) begin
                    state_d   = RD_IC;
                    wait_d    = '0;
                    mm_rd_d   = 1'b1;
                    mm_addr_d = {ic_addr_i[ADDR_SIZE-1:OFFS], {OFFS{1'b0}}};
                end else if (go_st || go_dc) begin
                    // I$ lost this arbitration: age it
                    if (ic_req && wait_q != WMAX) wait_d = wait_q + 1'b1;
                    if (go_st) begin
                        state_d   = WR;
                        mm_wr_d   = 1'b1;
                        st_ack_d  = 1'b1;
                        wr_addr_d = st_addr_i;
                        wr_data_d = st_data_i;
                        wr_type_d = st_type_i;
                    end else begin
                        state_d   = RD_DC;
                        mm_rd_d   = 1'b1;
                        mm_addr_d = {dc_addr_i[ADDR_SIZE-1:OFFS], {OFFS{1'b0}}};
                    end
                end
            end
            RD_IC, RD_DC: begin
                if (mm_data_rdy_i) begin
                    state_d  = IDLE;
                    mm_rd_d  = 1'b0;
                    rsp_d    = mm_rd_data_i;
                    ic_rdy_d = (state_q == RD_IC);
                    dc_rdy_d = (state_q == RD_DC);
                end
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, aging counter and output registers; reset aborts any transaction
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= IDLE;
            wait_q            <= '0;
            ic_rdy_o          <= 1'b0;
            dc_rdy_o          <= 1'b0;
            st_ack_o          <= 1'b0;
            rsp_data_o        <= '0;
            mm_rd_o           <= 1'b0;
            mm_addr_o         <= '0;
            mm_wr_o           <= 1'b0;
            mm_wr_addr_o      <= '0;
            mm_wr_data_o      <= '0;
            mm_wr_data_type_o <= BYTE;
        end else begin
            state_q           <= state_d;
            wait_q            <= wait_d;
            ic_rdy_o          <= ic_rdy_d;
            dc_rdy_o          <= dc_rdy_d;
            st_ack_o          <= st_ack_d;
            rsp_data_o        <= rsp_d;
            mm_rd_o           <= mm_rd_d;
            mm_addr_o         <= mm_addr_d;
            mm_wr_o           <= mm_wr_d;
            mm_wr_addr_o      <= wr_addr_d;
            mm_wr_data_o      <= wr_data_d;
            mm_wr_data_type_o <= wr_type_d;
        end
    end

endmodule

// File: tb/tb_segre_mm_arbiter.sv
// Bench for segre_mm_arbiter: cycle vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_segre_mm_arbiter;
    import segre_mm_pkg::*;

    localparam int ADDR_SIZE   = 32;
    localparam int WORD_SIZE   = 32;
    localparam int LANE_SIZE   = 128;
    localparam int IC_MAX_WAIT = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 ic_req_i, dc_req_i, st_req_i;
    logic [ADDR_SIZE-1:0] ic_addr_i, dc_addr_i, st_addr_i;
    logic [WORD_SIZE-1:0] st_data_i;
    memop_data_type_e     st_type_i;
    logic                 ic_rdy_o, dc_rdy_o, st_ack_o;
    logic [LANE_SIZE-1:0] rsp_data_o;
    logic                 mm_rd_o, mm_data_rdy_i, mm_wr_o;
    logic [ADDR_SIZE-1:0] mm_addr_o, mm_wr_addr_o;
    logic [LANE_SIZE-1:0] mm_rd_data_i;
    logic [WORD_SIZE-1:0] mm_wr_data_o;
    memop_data_type_e     mm_wr_data_type_o;

    segre_mm_arbiter #(
        .ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE),
        .LANE_SIZE(LANE_SIZE), .IC_MAX_WAIT(IC_MAX_WAIT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rdy_o(ic_rdy_o),
        .dc_req_i(dc_req_i), .dc_addr_i(dc_addr_i), .dc_rdy_o(dc_rdy_o),
        .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .st_type_i(st_type_i), .st_ack_o(st_ack_o),
        .rsp_data_o(rsp_data_o),
        .mm_rd_o(mm_rd_o), .mm_addr_o(mm_addr_o),
        .mm_data_rdy_i(mm_data_rdy_i), .mm_rd_data_i(mm_rd_data_i),
        .mm_wr_o(mm_wr_o), .mm_wr_addr_o(mm_wr_addr_o),
        .mm_wr_data_o(mm_wr_data_o), .mm_wr_data_type_o(mm_wr_data_type_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_base(input logic [31:0] a);
        return a & ~32'(LANE_SIZE / 8 - 1);
    endfunction

    task automatic do_reset();
        rst_i = 1'b1; ic_req_i = 1'b0; dc_req_i = 1'b0; st_req_i = 1'b0;
        mm_data_rdy_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Wait for the next grant; 0=I$ read, 1=D$ read, 2=store, -1=timeout.
    // Reads are answered by memory in their first cycle.
    task automatic next_grant(output int who);
        bit done;
        done = 1'b0;
        who  = -1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk_i);
            if (mm_wr_o) begin
                who  = 2;
                done = 1'b1;
            end else if (mm_rd_o) begin
                who = (mm_addr_o == lane_base(ic_addr_i)) ? 0 : 1;
                mm_data_rdy_i = 1'b1;
                @(negedge clk_i);
                mm_data_rdy_i = 1'b0;
                done = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic        rst, ic, dc, st, drdy;
        logic [4:0]  ctl;   // {ic_rdy, dc_rdy, st_ack, mm_rd, mm_wr}
        logic [31:0] addr;  // mm_addr_o while a read is out
    } vec_t;

    localparam int NV = 16;
    localparam logic [127:0] LANE = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    vec_t vt [NV];

    int         who, got, pulses, rises;
    logic       prev_rd;
    int         exp_seq [5];
    int         owner, age, w;   // owner: 0 none, 1 I$ read, 2 D$ read, 3 store
    logic [4:0]   e_ctl;
    logic [127:0] e_rsp;
    logic [31:0]  e_addr;

    initial begin
        // Each row: inputs for one cycle, outputs expected after that edge.
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 32'h0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00010, 32'h0000_1230};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00010, 32'h0000_1230};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00010, 32'h0000_1230};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b01000, 32'h0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 32'h0};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00101, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00000, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00010, 32'h0000_1230};
        vt[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b01000, 32'h0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010, 32'h0000_4560};
        vt[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b10000, 32'h0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 32'h0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 32'h0};
        vt[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 32'h0};

        ic_addr_i = 32'h0000_4567; dc_addr_i = 32'h0000_1234;
        st_addr_i = 32'h0000_2002; st_data_i = 32'hCAFE_BABE; st_type_i = HALF;
        mm_rd_data_i = LANE;

        for (int i = 0; i < NV; i++) begin
            rst_i = vt[i].rst; ic_req_i = vt[i].ic; dc_req_i = vt[i].dc;
            st_req_i = vt[i].st; mm_data_rdy_i = vt[i].drdy;
            @(negedge clk_i);
            chk($sformatf("vec%0d_ctl", i),
                128'({ic_rdy_o, dc_rdy_o, st_ack_o, mm_rd_o, mm_wr_o}), 128'(vt[i].ctl));
            if (vt[i].rst) begin
                chk("reset_rsp", rsp_data_o, 128'(0));
                chk("reset_addr", 128'(mm_addr_o), 128'(0));
                chk("reset_wtype", 128'(mm_wr_data_type_o), 128'(BYTE));
            end
            if (vt[i].ctl[1])
                chk($sformatf("vec%0d_addr", i), 128'(mm_addr_o), 128'(vt[i].addr));
            if (vt[i].ctl[0]) begin
                chk("vec_wr_addr", 128'(mm_wr_addr_o), 128'(32'h0000_2002));
                chk("vec_wr_data", 128'(mm_wr_data_o), 128'(32'hCAFE_BABE));
                chk("vec_wr_type", 128'(mm_wr_data_type_o), 128'(HALF));
            end
            if (vt[i].ctl[4] || vt[i].ctl[3])
                chk($sformatf("vec%0d_rsp", i), rsp_data_o, LANE);
        end

        // Aging: I$ held while a store is always pending; two rounds show the
        // counter restarts from zero after the I$ grant.
        exp_seq = '{2, 2, 2, 2, 0};
        do_reset();
        ic_addr_i = 32'h0000_0100; dc_addr_i = 32'h0000_0200;
        for (int r = 0; r < 2; r++) begin
            ic_req_i = 1'b1; dc_req_i = 1'b1; st_req_i = 1'b1;
            for (int g = 0; g < 5; g++) begin
                next_grant(who);
                chk($sformatf("age_r%0d_g%0d", r, g), 128'(who), 128'(exp_seq[g]));
            end
            ic_req_i = 1'b0; dc_req_i = 1'b0; st_req_i = 1'b0;
            @(negedge clk_i);
            @(negedge clk_i);
        end

        // Reset in the middle of an I$ read, then a late data return
        do_reset();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_ABCD;
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            @(negedge clk_i);
            if (mm_rd_o) got = 1;
        end
        chk("rstmid_rd_issued", 128'(got), 128'(1));
        rst_i = 1'b1; ic_req_i = 1'b0;
        @(negedge clk_i);
        chk("rstmid_rd_low", 128'(mm_rd_o), 128'(0));
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        mm_data_rdy_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            mm_data_rdy_i = 1'b0;
            chk($sformatf("rstmid_quiet%0d", k), 128'({ic_rdy_o, dc_rdy_o, mm_rd_o}), 128'(0));
        end

        // D$ drops req right after its grant: still one read, one pulse
        do_reset();
        dc_req_i = 1'b1; dc_addr_i = 32'h0000_5678;
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            @(negedge clk_i);
            if (mm_rd_o) got = 1;
        end
        chk("drop_rd_issued", 128'(got), 128'(1));
        dc_req_i = 1'b0;
        pulses = 0; rises = 1; prev_rd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mm_data_rdy_i = (k == 1);
            @(negedge clk_i);
            if (dc_rdy_o) pulses++;
            if (mm_rd_o && !prev_rd) rises++;
            prev_rd = mm_rd_o;
        end
        mm_data_rdy_i = 1'b0;
        chk("drop_rdy_cnt", 128'(pulses), 128'(1));
        chk("drop_rd_cnt", 128'(rises), 128'(1));

        // Random traffic against a transaction-level model
        do_reset();
        owner = 0; age = 0; e_rsp = '0; e_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            e_ctl = 5'b0;
            if (owner == 0) begin
                w = 0;
                if (ic_req_i && age >= IC_MAX_WAIT) w = 1;
                else if (st_req_i) w = 3;
                else if (dc_req_i) w = 2;
                else if (ic_req_i) w = 1;
                if ((w == 2 || w == 3) && ic_req_i && age < IC_MAX_WAIT) age++;
                if (w == 1) age = 0;
                owner = w;
                if (w == 1) begin e_ctl[1] = 1'b1; e_addr = lane_base(ic_addr_i); end
                if (w == 2) begin e_ctl[1] = 1'b1; e_addr = lane_base(dc_addr_i); end
                if (w == 3) begin e_ctl[2] = 1'b1; e_ctl[0] = 1'b1; end
            end else if (owner == 3) begin
                owner = 0;
            end else if (mm_data_rdy_i) begin
                if (owner == 1) e_ctl[4] = 1'b1;
                else            e_ctl[3] = 1'b1;
                e_rsp = mm_rd_data_i;
                owner = 0;
            end else begin
                e_ctl[1] = 1'b1;
            end
            chk("rnd_ctl", 128'({ic_rdy_o, dc_rdy_o, st_ack_o, mm_rd_o, mm_wr_o}), 128'(e_ctl));
            chk("rnd_rsp", rsp_data_o, e_rsp);
            if (e_ctl[1]) chk("rnd_rd_addr", 128'(mm_addr_o), 128'(e_addr));
            if (e_ctl[0]) begin
                chk("rnd_wr_addr", 128'(mm_wr_addr_o), 128'(st_addr_i));
                chk("rnd_wr_data", 128'(mm_wr_data_o), 128'(st_data_i));
                chk("rnd_wr_type", 128'(mm_wr_data_type_o), 128'(st_type_i));
            end
            // Requesters hold until their pulse, then drop and may re-request later
            if (e_ctl[4]) ic_req_i = 1'b0;
            else if (!ic_req_i && $urandom_range(3) == 0) begin
                ic_req_i = 1'b1; ic_addr_i = $urandom;
            end
            if (e_ctl[3]) dc_req_i = 1'b0;
            else if (!dc_req_i && $urandom_range(3) == 0) begin
                dc_req_i = 1'b1; dc_addr_i = $urandom;
            end
            if (e_ctl[2]) st_req_i = 1'b0;
            else if (!st_req_i && $urandom_range(4) == 0) begin
                st_req_i = 1'b1; st_addr_i = $urandom; st_data_i = $urandom;
                st_type_i = memop_data_type_e'(2'($urandom_range(2)));
            end
            if (owner == 1 || owner == 2) mm_data_rdy_i = ($urandom_range(2) == 0);
            else                          mm_data_rdy_i = ($urandom_range(7) == 0);
            mm_rd_data_i = {$urandom, $urandom, $urandom, $urandom};
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/segre_mm_arbiter.md
Name: segre_mm_arbiter

Overview:
- Single-port main-memory arbiter and sequencer between three requesters: I$ refill reads, D$ refill reads and D$ store write-through.
- Sits between the cache/MMU side and the core's main-memory pins (mm_*).
- Serialises one transaction at a time, holds the memory handshake, and routes the returned lane to the winner.
- Fixed priority (store > D$ > I$) with an aging override so I$ refills cannot starve.

Parameters:
- ADDR_SIZE, 32, byte-address width
- WORD_SIZE, 32, store data width
- LANE_SIZE, 128, refill lane width in bits (same for $I and $D)
- IC_MAX_WAIT, 4, lost arbitrations after which a waiting I$ request wins outright

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- ic_req_i  in  1  I$ miss read request, level
- ic_addr_i  in  ADDR_SIZE  I$ miss address
- ic_rdy_o  out  1  one-cycle pulse: rsp_data_o valid for I$
- dc_req_i  in  1  D$ miss read request, level
- dc_addr_i  in  ADDR_SIZE  D$ miss address
- dc_rdy_o  out  1  one-cycle pulse: rsp_data_o valid for D$
- st_req_i  in  1  store request, level
- st_addr_i  in  ADDR_SIZE  store byte address
- st_data_i  in  WORD_SIZE  store data
- st_type_i  in  memop_data_type_e  byte/half/word
- st_ack_o  out  1  one-cycle pulse: store issued
- rsp_data_o  out  LANE_SIZE  returned lane
- mm_rd_o  out  1  memory read request
- mm_addr_o  out  ADDR_SIZE  read address, lane-aligned
- mm_data_rdy_i  in  1  read data valid
- mm_rd_data_i  in  LANE_SIZE  read data
- mm_wr_o  out  1  memory write strobe
- mm_wr_addr_o  out  ADDR_SIZE  write address
- mm_wr_data_o  out  WORD_SIZE  write data
- mm_wr_data_type_o  out  memop_data_type_e  write size

Behaviour:
- **FSM states:** IDLE, RD_IC, RD_DC, WR. All outputs are registered.
- **Reset:** state=IDLE and wait_cnt=0. All outputs are 0. ST type output = BYTE encoding 0.
- **Arbitration in IDLE:**
  - If ic_req_i=1 and wait_cnt==IC_MAX_WAIT, go to RD_IC.
  - Otherwise go to WR if st_req_i, else RD_DC if dc_req_i, else RD_IC if ic_req_i, else stay in IDLE.
  - The winner's address (and store data/type) is latched at the transition.
- **Read states:**
  - mm_rd_o=1 from the first cycle in the state until the cycle mm_data_rdy_i is sampled high.
  - mm_addr_o = latched address with the low log2(LANE_SIZE/8) bits zeroed, stable for the whole transaction.
- **Read completion:** on mm_data_rdy_i=1 in RD_x:
  - Next cycle: rsp_data_o=mm_rd_data_i, the matching ic_rdy_o/dc_rdy_o pulses for exactly one cycle, mm_rd_o=0, state=IDLE.
  - rsp_data_o holds its value until the next completion.
- **Minimum read turnaround:** a request seen in IDLE at cycle N gives mm_rd_o=1 at N+1. If mm_data_rdy_i=1 at N+1, rdy pulses at N+2. A new arbitration happens in IDLE at N+2, so a back-to-back read issues at N+3.
- **WR state:**
  - mm_wr_o=1 and st_ack_o=1 for exactly one cycle, with address/data/type unmodified from the latch.
  - Next state is IDLE.
  - Writes are posted; there is no memory acknowledge.
- **wait_cnt:**
  - Increments (saturating at IC_MAX_WAIT) on every IDLE departure to WR or RD_DC while ic_req_i=1.
  - Clears on entry to RD_IC.
  - Unchanged otherwise.
- **Requester rules:** requesters hold req/addr/data until their rdy/ack.
  - If a requester drops req mid-transaction, the transaction completes and the pulse is still issued.
  - The rdy/ack cycle's req is not re-sampled (arbitration occurs one cycle later in IDLE), so no double-issue occurs.
- **Store-before-load ordering:** a pending store always precedes a pending D$ read unless the I$ aging override fires. The I$ override never reorders D$ traffic against stores.
- **Spurious data:** mm_data_rdy_i in IDLE or WR is ignored.
- **Reset mid-transaction:** go immediately to IDLE with outputs 0. A later mm_data_rdy_i for the aborted read is ignored, and no rdy pulse is issued.

Test Plan:
- dc_req_i=1, dc_addr_i=0x0000_1234; memory returns 0xDEAD..BEEF 3 cycles after mm_rd_o -> mm_addr_o=0x0000_1230 held with mm_rd_o=1 for 3 cycles, then one dc_rdy_o pulse with rsp_data_o equal to the returned lane; ic_rdy_o stays 0.
- st_req_i, dc_req_i and ic_req_i all asserted in the same cycle -> grant order WR (st_ack_o, mm_wr_addr_o=st_addr_i, type=HALF passed through), then RD_DC, then RD_IC; exactly one pulse each.
- ic_req_i held while st/dc requests are re-asserted continuously, IC_MAX_WAIT=4 -> after 4 non-I$ grants, the 5th grant is RD_IC; wait_cnt returns to 0.
- rst_i=1 while in RD_IC, then mm_data_rdy_i=1 two cycles after reset release -> no ic_rdy_o, mm_rd_o=0, state IDLE.
- mm_data_rdy_i pulsed while in IDLE -> no rdy pulse and no state change.
- dc_req_i dropped one cycle after grant -> transaction completes; one dc_rdy_o pulse; no second mm_rd_o.
